// File: rtl/rcv_drain_ctrl.sv
// UART receive drain controller: acknowledges each received byte, queues it in a
// show-ahead FIFO for the consumer, and keeps sticky drop/overrun/framing status.
module rcv_drain_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [7:0]               i_rcv_rx_data,
  input  logic                     i_rcv_data_ready,
  input  logic                     i_rcv_overrun_error,
  input  logic                     i_rcv_framing_error,
  output logic                     o_rcv_data_read,
  input  logic                     i_pop,
  output logic [7:0]               o_rd_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_drop_error,
  output logic                     o_overrun_seen,
  output logic [CNT_W-1:0]         o_framing_cnt,
  input  logic                     i_clr_status
);

  // state    | meaning
  // IDLE     | waiting for the receiver to present a byte
  // WRITE    | acknowledging; byte written to the FIFO at end of cycle
  // DROP     | acknowledging; FIFO full, byte discarded
  // ACK_WAIT | waiting for the receiver to release data_ready
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP, S_ACK_WAIT} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      L_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0]      L_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]    L_PTR_ONE = AW'(1);
  localparam logic [CNT_W-1:0] L_FRM_ONE = CNT_W'(1);

  state_t           r_state, w_next;
  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             r_ovr_d, r_frm_d;
  logic             r_drop_error, r_overrun_seen;
  logic [CNT_W-1:0] r_framing_cnt;
  logic             w_wr, w_drop, w_rd, w_ovr_edge, w_frm_edge;

  assign o_empty        = (r_count == '0);
  assign o_full         = (r_count == L_DEPTH);
  assign o_count        = r_count;
  assign o_rd_data      = o_empty ? 8'h00 : r_mem[r_rptr];
  assign o_drop_error   = r_drop_error;
  assign o_overrun_seen = r_overrun_seen;
  assign o_framing_cnt  = r_framing_cnt;

  assign w_rd       = i_pop && !o_empty;
  assign w_ovr_edge = i_rcv_overrun_error && !r_ovr_d;
  assign w_frm_edge = i_rcv_framing_error && !r_frm_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // A pop in the deciding IDLE cycle frees the slot the upcoming write needs.
  always_comb begin
    w_next          = r_state;
    w_wr            = 1'b0;
    w_drop          = 1'b0;
    o_rcv_data_read = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_rcv_data_ready) w_next = (!o_full || i_pop) ? S_WRITE : S_DROP;
      end
      S_WRITE: begin
        w_wr            = 1'b1;
        o_rcv_data_read = 1'b1;
        w_next          = S_ACK_WAIT;
      end
      S_DROP: begin
        w_drop          = 1'b1;
        o_rcv_data_read = 1'b1;
        w_next          = S_ACK_WAIT;
      end
      S_ACK_WAIT: begin
        if (!i_rcv_data_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_wr && !i_rst) r_mem[r_wptr] <= i_rcv_rx_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + L_PTR_ONE;
      if (w_rd) r_rptr <= r_rptr + L_PTR_ONE;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + L_CNT_ONE;
        2'b01:   r_count <= r_count - L_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Set/increment events take priority over a coincident clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovr_d        <= 1'b0;
      r_frm_d        <= 1'b0;
      r_drop_error   <= 1'b0;
      r_overrun_seen <= 1'b0;
      r_framing_cnt  <= '0;
    end else begin
      r_ovr_d <= i_rcv_overrun_error;
      r_frm_d <= i_rcv_framing_error;
      if (w_drop)            r_drop_error <= 1'b1;
      else if (i_clr_status) r_drop_error <= 1'b0;
      if (w_ovr_edge)        r_overrun_seen <= 1'b1;
      else if (i_clr_status) r_overrun_seen <= 1'b0;
      if (w_frm_edge) begin
        if (i_clr_status)        r_framing_cnt <= L_FRM_ONE;
        else if (!(&r_framing_cnt)) r_framing_cnt <= r_framing_cnt + L_FRM_ONE;
      end else if (i_clr_status) begin
        r_framing_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rcv_drain_ctrl.sv
// Bench for rcv_drain_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rcv_drain_ctrl;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int FRM_MAX = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx = 8'h00;
  logic       ready = 1'b0, ovr = 1'b0, frm = 1'b0, pop = 1'b0, clr = 1'b0;
  logic       rd_ack, empty, full, drop_err, ovr_seen;
  logic [7:0] rd_data;
  logic [$clog2(DEPTH):0] count;
  logic [CNT_W-1:0] frm_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  rcv_drain_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_rcv_rx_data(rx), .i_rcv_data_ready(ready),
    .i_rcv_overrun_error(ovr), .i_rcv_framing_error(frm), .o_rcv_data_read(rd_ack),
    .i_pop(pop), .o_rd_data(rd_data), .o_empty(empty), .o_full(full), .o_count(count),
    .o_drop_error(drop_err), .o_overrun_seen(ovr_seen), .o_framing_cnt(frm_cnt),
    .i_clr_status(clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: byte queue plus the receiver transaction in flight.
  // m_txn: 0 none, 1 byte accepted (ack, store), 2 byte refused (ack, discard),
  // 3 acknowledged, receiver still holding data_ready.
  bit [7:0] m_q[$];
  int       m_txn = 0;
  bit       m_drop = 0, m_ovr = 0, m_ovr_d = 0, m_frm_d = 0;
  int       m_frm = 0;
  bit       m_valid = 0;

  always @(posedge clk) begin
    int  sz;
    bit  f_edge, o_edge;
    if (rst) begin
      m_q.delete();
      m_txn = 0; m_drop = 0; m_ovr = 0; m_frm = 0; m_ovr_d = 0; m_frm_d = 0;
      m_valid = 1;
    end else begin
      sz     = m_q.size();
      f_edge = frm && !m_frm_d;
      o_edge = ovr && !m_ovr_d;
      if (pop && sz > 0) void'(m_q.pop_front());
      if (m_txn == 1) m_q.push_back(rx);
      if (m_txn == 2) m_drop = 1; else if (clr) m_drop = 0;
      if (o_edge) m_ovr = 1; else if (clr) m_ovr = 0;
      if (f_edge) m_frm = clr ? 1 : (m_frm < FRM_MAX ? m_frm + 1 : FRM_MAX);
      else if (clr) m_frm = 0;
      m_frm_d = frm;
      m_ovr_d = ovr;
      if (m_txn == 0) begin
        if (ready) m_txn = (sz < DEPTH || pop) ? 1 : 2;
      end else if (m_txn == 3) begin
        if (!ready) m_txn = 0;
      end else begin
        m_txn = 3;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("m_count",    int'(count),    m_q.size());
      check("m_empty",    int'(empty),    int'(m_q.size() == 0));
      check("m_full",     int'(full),     int'(m_q.size() == DEPTH));
      check("m_rd_data",  int'(rd_data),  (m_q.size() > 0) ? int'(m_q[0]) : 0);
      check("m_data_read",int'(rd_ack),   int'(m_txn == 1 || m_txn == 2));
      check("m_drop_err", int'(drop_err), int'(m_drop));
      check("m_overrun",  int'(ovr_seen), int'(m_ovr));
      check("m_framing",  int'(frm_cnt),  m_frm);
    end
  end

  // Receiver side of the handshake: data_ready held one cycle past the ack.
  task automatic deliver(input logic [7:0] b, input bit with_pop);
    int pulses = 0;
    bit got = 0;
    rx = b; ready = 1'b1; pop = with_pop;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      pop = 1'b0;
      if (rd_ack) begin got = 1; pulses++; end
    end
    if (!got) check("ack_timeout", 0, 1);
    @(negedge clk);
    if (rd_ack) pulses++;
    ready = 1'b0;
    @(negedge clk);
    if (rd_ack) pulses++;
    check("ack_pulses", pulses, 1);
  endtask

  task automatic pop_expect(input logic [7:0] exp);
    check("pop_head", int'(rd_data), int'(exp));
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
  endtask

  task automatic frm_pulse();
    frm = 1'b1; @(negedge clk);
    frm = 1'b0; @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int hold = 0;
    bit got;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_count", int'(count), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_data_read", int'(rd_ack), 0);
    check("rst_status", int'({drop_err, ovr_seen}) + int'(frm_cnt), 0);

    pop = 1'b1; @(negedge clk); pop = 1'b0;
    check("pop_empty_count", int'(count), 0);
    check("pop_empty_drop", int'(drop_err), 0);

    deliver(8'hD5, 0);
    check("single_count", int'(count), 1);
    check("single_data", int'(rd_data), 8'hD5);
    pop_expect(8'hD5);
    check("single_empty", int'(empty), 1);
    check("single_rd_zero", int'(rd_data), 0);

    deliver(8'h11, 0); deliver(8'h22, 0); deliver(8'h33, 0); deliver(8'h44, 0);
    check("fill_full", int'(full), 1);
    deliver(8'h55, 0);
    check("drop_flag", int'(drop_err), 1);
    check("drop_count", int'(count), 4);
    pop_expect(8'h11); pop_expect(8'h22); pop_expect(8'h33); pop_expect(8'h44);
    check("drain_empty", int'(empty), 1);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    check("clr_drop", int'(drop_err), 0);

    deliver(8'h11, 0); deliver(8'h22, 0); deliver(8'h33, 0); deliver(8'h44, 0);
    deliver(8'h55, 1);
    check("fullpop_count", int'(count), 4);
    check("fullpop_no_drop", int'(drop_err), 0);
    check("fullpop_head", int'(rd_data), 8'h22);
    pop_expect(8'h22); pop_expect(8'h33); pop_expect(8'h44); pop_expect(8'h55);

    frm_pulse(); frm_pulse(); frm_pulse();
    check("framing_3", int'(frm_cnt), 3);
    ovr = 1'b1; @(negedge clk); ovr = 1'b0; @(negedge clk);
    check("overrun_set", int'(ovr_seen), 1);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    check("clr_all", int'({drop_err, ovr_seen}) + int'(frm_cnt), 0);
    frm = 1'b1; clr = 1'b1; @(negedge clk); clr = 1'b0; frm = 1'b0; @(negedge clk);
    check("clr_vs_edge", int'(frm_cnt), 1);
    for (int i = 0; i < 300; i++) frm_pulse();
    check("framing_sat", int'(frm_cnt), FRM_MAX);
    clr = 1'b1; @(negedge clk); clr = 1'b0;

    deliver(8'h01, 0);
    rx = 8'h02; ready = 1'b1; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rd_ack) got = 1;
    end
    if (!got) check("ack_timeout_mid", 0, 1);
    @(negedge clk);
    check("mid_count", int'(count), 2);
    rst = 1'b1; ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_empty", int'(empty), 1);
    deliver(8'hA5, 0);
    check("post_rst_data", int'(rd_data), 8'hA5);
    check("post_rst_count", int'(count), 1);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      pop = ($urandom_range(0, 3) == 0);
      frm = ($urandom_range(0, 7) == 0);
      ovr = ($urandom_range(0, 15) == 0);
      clr = ($urandom_range(0, 31) == 0);
      if (ready) begin
        if (rd_ack) hold = $urandom_range(1, 3);
        else if (hold > 0) begin
          hold--;
          if (hold == 0) ready = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        rx = 8'($urandom);
        ready = 1'b1;
      end
    end
    @(negedge clk);
    pop = 1'b0; frm = 1'b0; ovr = 1'b0; clr = 1'b0;
    if (ready && !rd_ack && hold == 0) ready = 1'b1;
    repeat (4) @(negedge clk);
    ready = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
